serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial adder: the addition counterpart to the team's subtractor cells.
//   Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
//   Uses a single full-adder cell and a carry flip-flop under a start/busy/done handshake.
//   Intended for area-constrained datapaths where a WIDTH-wide ripple adder is too costly.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (>= 1)
// PORTS
//   clk     in   1      rising-edge clock, the only clock
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  operand A, captured when start is accepted
//   b       in   WIDTH  operand B, captured when start is accepted
//   cin     in   1      carry-in, captured when start is accepted
//   busy    out  1      high in RUN and DONE; start is ignored while high
//   done    out  1      one-cycle pulse; result is valid
//   sum     out  WIDTH  result register; holds the last completed result
//   cout    out  1      carry-out of the last completed result
// BEHAVIOUR
// - Reset
//   - rst_n low forces, immediately: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0.
//   - Reset asserted mid-operation aborts the operation. No partial result reaches sum or cout.
// - States: IDLE -> RUN -> DONE -> IDLE
//   - IDLE: if start=1 at edge k, latch a, b and cin into internal shift and carry registers.
//     Clear the counter and go to RUN. busy goes high after edge k.
//   - RUN: at each edge k+1..k+WIDTH, process one bit:
//     - s = a_sh[0] ^ b_sh[0] ^ c
//     - c <= (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]))
//     - shift a_sh and b_sh right by one; shift s into the MSB of the internal result register
//     - increment the counter
//   - At edge k+WIDTH (last bit): copy the completed internal result to sum and the final carry
//     to cout, then go to DONE.
//   - DONE: done=1 for exactly one cycle, then go to IDLE at edge k+WIDTH+1. done and busy
//     fall together.
// - Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start is
//   accepted. Back-to-back ops: start may be held high; the next op is accepted at the first
//   edge in IDLE.
// - Input capture: start held high or asserted in RUN/DONE has no effect. a, b and cin may
//   change freely after acceptance.
// - Output stability: sum and cout change only at the completion edge. They hold their value
//   through IDLE and through the next RUN.
// - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
//   - Overflow beyond WIDTH bits appears only in cout.
//   - With WIDTH=1 the block is a registered full adder with latency 2.
// - The counter is $clog2(WIDTH+1) bits wide and never wraps during an op.
// TESTING (WIDTH=8 unless noted)
//   1. Reset, then a=00 b=00 cin=0, start -> after 9 cycles: done=1, sum=00, cout=0; busy=1
//      throughout.
//   2. a=FF b=01 cin=0 -> sum=00 cout=1. Then a=A5 b=5A cin=1 -> sum=00 cout=1.
//      Then a=3C b=42 cin=0 -> sum=7E cout=0.
//   3. Pulse start again 3 cycles into an op, with different operands -> ignored; first result
//      is unchanged; done pulses exactly once.
//   4. rst_n low 4 cycles into an op -> busy=0, done=0, sum=00 immediately. A new op after
//      release gives the correct result.
//   5. start held high continuously -> successive done pulses every 10 cycles.
//      sum is stable between pulses.
//   6. WIDTH=3: all 128 a/b/cin combinations compared against a+b+cin; done latency is exactly
//      4 cycles each.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process the operands LSB first,
// one bit per clock, behind a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_c;
  logic [WIDTH-1:0] r_res;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_sum_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_nxt;

  always_comb begin
    w_sum_bit = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    w_carry   = (r_a_sh[0] & r_b_sh[0]) | (r_c & (r_a_sh[0] ^ r_b_sh[0]));
    // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    w_res_nxt            = r_res >> 1;
    w_res_nxt[WIDTH-1]   = w_sum_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_c     <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_c     <= cin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_c    <= w_carry;
          r_res  <= w_res_nxt;
          r_cnt  <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_sum   <= w_res_nxt;
            r_cout  <= w_carry;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake/reset behaviour and a
// 3-bit instance swept over every operand combination.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start3;
  logic [2:0] a3;
  logic [2:0] b3;
  logic       cin3;
  logic       busy3;
  logic       done3;
  logic [2:0] sum3;
  logic       cout3;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start3),
    .a    (a3),
    .b    (b3),
    .cin  (cin3),
    .busy (busy3),
    .done (done3),
    .sum  (sum3),
    .cout (cout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op8(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                         input logic ci, input logic [7:0] es, input logic ec);
    int n;
    logic busy_ok;
    a = ai; b = bi; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_busy_run"}, {31'd0, busy_ok & busy}, 1);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    tick();
    check({tag, "_done_fall"}, {31'd0, done}, 0);
    check({tag, "_busy_fall"}, {31'd0, busy}, 0);
  endtask

  task automatic run_op3(input logic [2:0] ai, input logic [2:0] bi, input logic ci);
    int n;
    logic [3:0] exp;
    exp = {1'b0, ai} + {1'b0, bi} + {3'd0, ci};
    a3 = ai; b3 = bi; cin3 = ci; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 1;
    while (!done3 && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("w3_lat_%0h_%0h_%0h", ai, bi, ci), n, 4);
    check($sformatf("w3_sum_%0h_%0h_%0h", ai, bi, ci), {29'd0, sum3}, {29'd0, exp[2:0]});
    check($sformatf("w3_cout_%0h_%0h_%0h", ai, bi, ci), {31'd0, cout3}, {31'd0, exp[3]});
    tick();
  endtask

  initial begin
    int pulses;
    int t_first;
    int t_prev;
    int n;
    logic stable_ok;
    logic gap_ok;

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic operations
    run_op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op8("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run_op8("3c_42", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);

    // Start pulsed mid-operation must be ignored
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      tick();
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_sum", {24'd0, sum}, 32'h46);
    check("ignore_cout", {31'd0, cout}, 0);
    check("ignore_idle", {31'd0, busy}, 0);

    // Asynchronous reset mid-operation
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_sum", {24'd0, sum}, 0);
    check("arst_cout", {31'd0, cout}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_hold_sum", {24'd0, sum}, 0);
    run_op8("after_rst", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

    // Start held high: done every 10 cycles, sum stable between pulses
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    pulses = 0; t_first = -1; t_prev = -1;
    stable_ok = 1'b1; gap_ok = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (done) begin
        if (t_prev >= 0 && (i - t_prev) != 10) gap_ok = 1'b0;
        if (t_first < 0) t_first = i;
        t_prev = i;
        pulses++;
      end
      if (t_first >= 0 && sum !== 8'h30) stable_ok = 1'b0;
    end
    start = 1'b0;
    check("held_pulses", pulses, 3);
    check("held_first", t_first, 8);
    check("held_gap", {31'd0, gap_ok}, 1);
    check("held_stable", {31'd0, stable_ok}, 1);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("held_drain", {31'd0, busy}, 0);

    // Exhaustive 3-bit sweep
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      run_op3(v[5:3], v[2:0], v[6]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
